// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: geometry constants and the loader state encoding.
package imem_pkg;

    localparam int IMEM_ADDR_W = 13;
    localparam int IMEM_DEPTH  = 8192;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_full flags the byte that completes a word.
module imem_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (clear) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (shift_en) begin
            idx  <= idx + 2'd1;
            word <= {word[23:0], byte_in};
        end
    end

    // Index wraps back to 0 naturally after the 4th byte.
    assign word_full = shift_en && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: packs bytes into words, writes them from address 0, holds the CPU until done.
// Optional trailer-checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum_out
`endif
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    loader_state_t state, next_state;
    logic          clear;
    logic          shift_en;
    logic          word_full;
    logic          last_flag;
    logic          write_next;

    assign byte_ready = (state == LOAD);
    assign shift_en   = byte_ready && byte_valid;

    imem_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .shift_en (shift_en),
        .byte_in  (byte_in),
        .word     (wr_data),
        .word_full(word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_check;

    assign sum_check    = sum + wr_data;
    assign checksum_out = sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                    clear      = 1'b1;
                end
            end
            LOAD: begin
                if (word_full) begin
                    next_state = WRITE;
                end else if (shift_en && byte_last) begin
                    next_state = ERR;
                end
            end
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (last_flag) begin
                    next_state = (sum_check == '0) ? DONE : ERR;
                end else if (word_count == LAST_CNT) begin
                    next_state = ERR;
                end else begin
                    next_state = LOAD;
                end
`else
                if (last_flag) begin
                    next_state = DONE;
                end else if (word_count == LAST_CNT) begin
                    next_state = ERR;
                end else begin
                    next_state = LOAD;
                end
`endif
            end
            DONE, ERR: begin
                if (start) begin
                    next_state = LOAD;
                    clear      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The trailer word passes through WRITE for the sum check but never strobes memory.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign write_next = (next_state == WRITE) && !byte_last;
`else
    assign write_next = (next_state == WRITE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            last_flag  <= 1'b0;
        end else begin
            wr_en    <= write_next;
            busy     <= (next_state == LOAD) || (next_state == WRITE);
            done     <= (next_state == DONE);
            error    <= (next_state == ERR);
            cpu_hold <= (next_state != DONE);
            if (next_state == WRITE) begin
                wr_addr <= word_count[ADDR_W-1:0];
            end
            if (word_full) begin
                last_flag <= byte_last;
            end
            if (clear) begin
                word_count <= '0;
                last_flag  <= 1'b0;
            end else if (wr_en) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (wr_en) begin
            sum <= sum_check;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader with a word-level reference model of each image load.
module tb_imem_loader;

    localparam int AW = 3;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_last = 1'b0;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   checksum_out;
`endif

    imem_loader #(.ADDR_W(AW), .DEPTH(DP), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_last (byte_last),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum_out(checksum_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_sum;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every memory write is matched against the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {63'd0, wr_en}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {61'd0, wr_addr}, {61'd0, e.addr});
                    chk("wr_data", {32'd0, wr_data}, {32'd0, e.data});
                    chk("ready_in_write", {63'd0, byte_ready}, 64'd0);
                end
            end
        end
    end

    // Reference model: group the image into MSB-first words and apply the load rules.
    task automatic model(input logic [7:0] b[$], input bit has_last,
                         output int exp_cnt, output bit exp_done);
        int          nfull;
        bit          decided;
        bit          is_last;
        logic [31:0] w;
        logic [31:0] sum;
        nfull    = b.size() / 4;
        decided  = 0;
        exp_cnt  = 0;
        exp_done = 0;
        sum      = 0;
        for (int k = 0; k < nfull; k++) begin
            if (k == DP) begin
                decided = 1;
                break;
            end
            w       = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
            is_last = has_last && (4*k + 3 == b.size() - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (is_last) begin
                exp_done = ((sum + w) == 32'd0);
                decided  = 1;
                break;
            end
`endif
            exp_q.push_back('{addr: AW'(k), data: w});
            exp_cnt++;
            sum = sum + w;
            if (is_last) begin
                exp_done = 1;
                decided  = 1;
                break;
            end
        end
        if (!decided) exp_done = 0;
        exp_sum = sum;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_done_clr", {63'd0, done}, 64'd0);
        chk("start_err_clr", {63'd0, error}, 64'd0);
        chk("start_cnt_clr", {60'd0, word_count}, 64'd0);
        chk("start_busy", {63'd0, busy}, 64'd1);
        chk("start_hold", {63'd0, cpu_hold}, 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap, output bit acc);
        acc = 0;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        byte_in    = b;
        byte_last  = last;
        byte_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                acc = 1;
                break;
            end
            if (done || error) break;
        end
        if (acc) begin
            @(posedge clk); #1;
        end else if (!(done || error)) begin
            chk("byte_accept_timeout", {63'd0, byte_ready}, 64'd1);
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic wait_end();
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done || error) break;
        end
        if (!(done || error)) chk("end_timeout", {63'd0, done | error}, 64'd1);
    endtask

    task automatic run_load(input logic [7:0] b[$], input bit has_last, input int max_gap);
        int exp_cnt;
        bit exp_done;
        bit acc;
        bit all_acc;
        bit last_b;
        model(b, has_last, exp_cnt, exp_done);
        start_pulse();
        all_acc = 1;
        for (int i = 0; i < b.size(); i++) begin
            last_b = has_last && (i == b.size() - 1);
            send_byte(b[i], last_b, $urandom_range(0, max_gap), acc);
            if (!acc) begin
                all_acc = 0;
                break;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (i % 4 == 3 && !last_b) begin
`else
            if (i % 4 == 3) begin
`endif
                @(negedge clk);
                chk("write_latency", {63'd0, wr_en}, 64'd1);
            end
        end
        if (all_acc && has_last && (b.size() % 4 != 0)) begin
            @(negedge clk);
            chk("partial_err_latency", {63'd0, error}, 64'd1);
            chk("partial_no_write", {63'd0, wr_en}, 64'd0);
        end
        wait_end();
        @(negedge clk);
        chk("done", {63'd0, done}, {63'd0, exp_done});
        chk("error", {63'd0, error}, {63'd0, !exp_done});
        chk("cpu_hold", {63'd0, cpu_hold}, {63'd0, !exp_done});
        chk("busy_end", {63'd0, busy}, 64'd0);
        chk("ready_end", {63'd0, byte_ready}, 64'd0);
        chk("word_count", {60'd0, word_count}, exp_cnt);
        chk("writes_pending", exp_q.size(), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("checksum_out", {32'd0, checksum_out}, {32'd0, exp_sum});
`endif
        exp_q.delete();
    endtask

    task automatic chk_reset();
        chk("rst_ready", {63'd0, byte_ready}, 64'd0);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_hold", {63'd0, cpu_hold}, 64'd1);
        chk("rst_addr", {61'd0, wr_addr}, 64'd0);
        chk("rst_data", {32'd0, wr_data}, 64'd0);
        chk("rst_count", {60'd0, word_count}, 64'd0);
    endtask

    initial begin
        logic [7:0] img[$];
        bit         acc;
        int         nw;

        #12;
        chk_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Nominal two-word image, no gaps.
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        run_load(img, 1, 0);

        // Same image with random gaps must produce identical writes.
        run_load(img, 1, 3);

        // Partial final word.
        img = '{8'hAA, 8'hBB};
        run_load(img, 1, 0);

        // Overflow: nine words, no last byte.
        img.delete();
        for (int i = 0; i < 36; i++) img.push_back(8'($urandom));
        run_load(img, 0, 1);

        // Randomised complete and partial images.
        for (int r = 0; r < 6; r++) begin
            img.delete();
            nw = $urandom_range(1, DP);
            for (int i = 0; i < 4 * nw; i++) img.push_back(8'($urandom));
            if (r == 5) void'(img.pop_back());
            run_load(img, 1, 2);
        end

        // Reset mid-load after six bytes, then a one-word image.
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q.push_back('{addr: AW'(0), data: 32'h11223344});
        start_pulse();
        for (int i = 0; i < 6; i++) send_byte(img[i], 0, 0, acc);
        repeat (2) @(negedge clk);
        chk("midload_writes_seen", exp_q.size(), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        img = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(img, 1, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                8'hFF, 8'hFF, 8'hFF, 8'hFD};
        run_load(img, 1, 1);
        img[11] = 8'hFE;
        run_load(img, 1, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
